// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding, default widths and counter helper for pipe_stage_skid
package pipe_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int CTRL_W_DEF = 4;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_t;

  // Saturating increment of a w-bit value carried in 32 bits (1 <= w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = 32'hFFFF_FFFF >> (32 - w);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one pipeline register slot: {data, ctrl} with load enable, valid bit and ctrl clear
module pipe_slot #(
  parameter int W  = 68,
  parameter int CW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         valid_d,
  input  logic         ctrl_clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      q     <= '0;
    end else begin
      valid <= valid_d;
      if (load)
        q <= d;
      // ctrl lives in the low CW bits; clearing wins over a same-cycle load
      if (ctrl_clr)
        q[CW-1:0] <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with 2-entry skid buffer; PIPE_PERF_CNT_EN adds stall/flush counters
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
`ifdef PIPE_PERF_CNT_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_PERF_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int W = DATA_W + CTRL_W;

  state_t         state, state_n;
  logic           main_valid, skid_valid;
  logic [W-1:0]   main_q, skid_q, main_d;
  logic           main_load, skid_load, main_sel_skid;
  logic           accept, emit;

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign accept    = in_valid & in_ready;
  assign emit      = main_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= ST_EMPTY;
    else
      state <= state_n;
  end

  always_comb begin
    state_n       = state;
    main_load     = 1'b0;
    skid_load     = 1'b0;
    main_sel_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_n   = ST_ONE;
          main_load = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && emit) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_n   = ST_FULL;
          skid_load = 1'b1;
        end else if (emit) begin
          state_n = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (emit) begin
          state_n       = ST_ONE;
          main_load     = 1'b1;
          main_sel_skid = 1'b1;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
    // Flush drops everything; data bits are left untouched, only ctrl is cleared
    if (flush) begin
      state_n   = ST_EMPTY;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  assign main_d = main_sel_skid ? skid_q : {in_data, in_ctrl};

  pipe_slot #(.W(W), .CW(CTRL_W)) u_main (
    .clk      (clk),
    .rst      (rst),
    .load     (main_load),
    .valid_d  (state_n != ST_EMPTY),
    .ctrl_clr (flush),
    .d        (main_d),
    .valid    (main_valid),
    .q        (main_q)
  );

  pipe_slot #(.W(W), .CW(CTRL_W)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .valid_d  (state_n == ST_FULL),
    .ctrl_clr (flush),
    .d        ({in_data, in_ctrl}),
    .valid    (skid_valid),
    .q        (skid_q)
  );

  assign out_data = main_q[W-1:CTRL_W];
  assign out_ctrl = main_q[CTRL_W-1:0] & {CTRL_W{main_valid}};

`ifdef PIPE_PERF_CNT_EN
  logic discard;
  // A head entry emitted during the flush cycle was delivered, not discarded
  assign discard = flush & (skid_valid | (main_valid & !emit) | accept);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_valid && !out_ready)
        stall_cnt <= CNT_W'(sat_inc(32'(stall_cnt), CNT_W));
      if (discard)
        flush_cnt <= CNT_W'(sat_inc(32'(flush_cnt), CNT_W));
    end
  end
`endif

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline stage register, the successor to the fixed-field inter-stage latches (IF/ID … MEM/WB).
- Carries an opaque DATA_W payload (PC, rd, ALU result, memory data) and a CTRL_W control bundle (RegWrite, WDSel, …).
- Uses a valid/ready handshake with a 2-entry skid buffer, so back-pressure does not need a combinational ready path.
- Provides a synchronous flush, and gates control to zero on bubbles so downstream write-enables never fire on invalid slots.

Parameters:
DATA_W, 64, payload width in bits.
CTRL_W, 4, control bundle width in bits; zeroed whenever invalid.
CNT_W, 16, performance counter width; used only with PIPE_PERF_CNT_EN.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-low reset; state clears immediately while rst=0.
flush  in  1  synchronous flush; kills all held entries.
in_valid  in  1  upstream beat valid.
in_ready  out  1  stage can accept a beat; registered output.
in_data  in  DATA_W  upstream payload.
in_ctrl  in  CTRL_W  upstream control bundle.
out_valid  out  1  downstream beat valid.
out_ready  in  1  downstream accepts the beat.
out_data  out  DATA_W  payload of the head entry.
out_ctrl  out  CTRL_W  control of the head entry; 0 when out_valid=0.

Behaviour:
- Storage:
  - main slot drives the out_* ports.
  - skid slot holds at most one beat accepted while the main slot is stalled.
- Handshakes:
  - Accept occurs when in_valid & in_ready.
  - Emit occurs when out_valid & out_ready.
  - in_ready = !skid_valid, taken from a flop; there is no combinational path from out_ready to in_ready.
- States:
  - EMPTY: main and skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: main and skid valid.
- Transitions:
  - EMPTY + accept -> ONE; main <= in.
  - ONE + accept & emit -> ONE; main <= in.
  - ONE + accept & !emit -> FULL; skid <= in.
  - ONE + emit & !accept -> EMPTY.
  - FULL + emit -> ONE; main <= skid. No accept is possible in FULL because in_ready=0.
  - Every other case holds state.
- Timing and ordering:
  - Latency from accept to out_valid is 1 cycle.
  - Sustained throughput is 1 beat/cycle while out_ready=1.
  - Order is strictly FIFO.
- Reset (rst=0, asynchronous):
  - out_valid=0, out_data=0, out_ctrl=0, in_ready=1.
  - Skid slot cleared; state EMPTY.
  - Reset may arrive mid-transfer; any held beats are lost, with no partial output.
- Flush:
  - On a clock edge with flush=1, next state is EMPTY and both slots' ctrl are cleared; data bits are held.
  - Flush takes priority over accept in the same cycle: the beat counts as handshaken upstream but is discarded.
  - An emit in the flush cycle completes normally, since downstream already sampled it.
- Bubble gating: out_ctrl = main_ctrl & {CTRL_W{out_valid}}.
- Invariants:
  - skid_valid implies main_valid.
  - in_ready=0 only in FULL.
  - in_data and in_ctrl are don't-care when in_valid=0.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: adds two outputs, both CNT_W wide, both reset to 0, both saturating at all-ones with no wrap:
  - stall_cnt: +1 on each cycle with out_valid & !out_ready.
  - flush_cnt: +1 on each flush cycle that discards at least one valid entry, including a beat accepted in that same cycle.
- Undefined: the ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package pipe_pkg holds:
  - the state enum {ST_EMPTY, ST_ONE, ST_FULL};
  - the default width localparams;
  - the counter saturation helper function.
- One sub-module, pipe_slot(W = DATA_W + CTRL_W): a single register with load enable, valid bit and ctrl clear. It is instantiated twice, as main and as skid.

Test Plan:
- Reset: hold rst=0 mid-stream with 2 beats buffered -> out_valid=0, out_ctrl=0, out_data=0 and in_ready=1 immediately, without waiting for a clock edge.
- Streaming: out_ready=1, send data 0x1..0x8 with ctrl=4'hF back-to-back -> out matches in order, each 1 cycle after accept, in_ready stays 1.
- Back-pressure:
  - Send 0xA then 0xB while out_ready=0 -> state FULL, in_ready=0 on the following cycle, out_data=0xA held.
  - Then out_ready=1 -> emits 0xA, then 0xB, with no loss and no duplication.
- Flush priority: in FULL, assert flush together with in_valid carrying 0xC -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and 0xC is never emitted.
- Bubble gating: in_ctrl=4'hF with in_valid=0 for 5 cycles -> out_ctrl stays 0 throughout.
- Counters (PIPE_PERF_CNT_EN, CNT_W=4):
  - Stall for 20 cycles -> stall_cnt saturates at 4'hF.
  - One flush of a valid entry -> flush_cnt=1.
